// File: rtl/strt_validator.sv
// Start-bit qualifier for the UART receiver on the oversampling clock.
// Majority-votes samples around the start-bit centre; flags glitches.
module strt_validator #(
  parameter int PRESCALE_W = 6,
  parameter int SAMPLES    = 3,
  parameter int CNT_W      = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SC_EN,
  input  logic                  SC_RX_IN,
  input  logic [PRESCALE_W-1:0] SC_Prescale,
  input  logic                  SC_clr_cnt,
  output logic                  SC_start_ok,
  output logic                  SC_glitch,
  output logic                  SC_busy,
  output logic                  SC_cfg_err,
  output logic [CNT_W-1:0]      SC_glitch_cnt
);

  localparam int H  = (SAMPLES - 1) / 2;
  localparam int VW = $clog2(SAMPLES + 1);
  localparam logic [PRESCALE_W-1:0] HALF = PRESCALE_W'(H);
  localparam logic [VW-1:0]         NEED = VW'(H + 1);
  localparam logic [31:0]           MINP = 32'(2 * SAMPLES);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    WAIT_END
  } state_t;

  state_t state;
  state_t stateNext;

  logic                  rxPrev;
  logic [PRESCALE_W-1:0] pLat;
  logic [PRESCALE_W-1:0] tick;
  logic [VW-1:0]         zeros;
  logic [VW-1:0]         zerosNext;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] winLo;
  logic [PRESCALE_W-1:0] winHi;
  logic [PRESCALE_W-1:0] lastTick;
  logic                  fallEdge;
  logic                  inWin;
  logic                  verdict;
  logic                  pass;
  logic                  lastHit;
  logic                  startOkNext;
  logic                  glitchNext;

  assign SC_cfg_err = (32'(SC_Prescale) < MINP);
  assign SC_busy    = (state != IDLE);

  assign fallEdge  = rxPrev & ~SC_RX_IN;
  assign mid       = pLat >> 1;
  assign winLo     = mid - HALF;
  assign winHi     = mid + HALF;
  assign lastTick  = pLat - PRESCALE_W'(1);
  assign inWin     = (tick >= winLo) && (tick <= winHi);
  assign zerosNext = zeros + VW'(inWin && !SC_RX_IN);
  assign verdict   = (tick == winHi);
  assign pass      = (zerosNext >= NEED);
  assign lastHit   = (tick == lastTick);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic; disable forces idle from anywhere
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:
        if (fallEdge && !SC_cfg_err)
          stateNext = SAMPLE;
      SAMPLE:
        if (verdict)
          stateNext = (pass && !lastHit) ? WAIT_END : IDLE;
      WAIT_END:
        if (lastHit)
          stateNext = IDLE;
      default:
        stateNext = IDLE;
    endcase
    if (!SC_EN) stateNext = IDLE;
  end

  // Pulse decode; a verdict on the last tick reports start directly
  always_comb begin
    startOkNext = 1'b0;
    glitchNext  = 1'b0;
    if (SC_EN) begin
      unique case (1'b1)
        (state == SAMPLE) && verdict: begin
          glitchNext  = !pass;
          startOkNext = pass && lastHit;
        end
        (state == WAIT_END):
          startOkNext = lastHit;
        default: ;
      endcase
    end
  end

  // Edge history, tick/vote counters, latched prescale and pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      rxPrev      <= 1'b1;
      tick        <= '0;
      zeros       <= '0;
      pLat        <= '0;
      SC_start_ok <= 1'b0;
      SC_glitch   <= 1'b0;
    end else begin
      rxPrev      <= SC_RX_IN;
      SC_start_ok <= startOkNext;
      SC_glitch   <= glitchNext;
      if (stateNext == IDLE) begin
        tick  <= '0;
        zeros <= '0;
      end else if (state == IDLE) begin
        tick  <= PRESCALE_W'(1);
        zeros <= '0;
        pLat  <= SC_Prescale;
      end else begin
        tick  <= tick + PRESCALE_W'(1);
        zeros <= zerosNext;
      end
    end
  end

  // Saturating glitch counter; clear wins over increment
  always_ff @(posedge CLK) begin
    if (RST || SC_clr_cnt)
      SC_glitch_cnt <= '0;
    else if (glitchNext && (SC_glitch_cnt != '1))
      SC_glitch_cnt <= SC_glitch_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_strt_validator.sv
// Directed bench for strt_validator.
// Unit A: SAMPLES=3, CNT_W=2. Unit B: SAMPLES=5.
module tb_strt_validator;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       enA = 1'b0;
  logic       enB = 1'b0;
  logic       rx  = 1'b1;
  logic       clr = 1'b0;
  logic [5:0] pre = 6'd8;

  logic       okA, glA, busyA, cfgA;
  logic [1:0] cntA;
  logic       okB, glB, busyB, cfgB;
  logic [7:0] cntB;

  strt_validator #(
    .PRESCALE_W(6), .SAMPLES(3), .CNT_W(2)
  ) dutA (
    .CLK(CLK), .RST(RST), .SC_EN(enA),
    .SC_RX_IN(rx), .SC_Prescale(pre),
    .SC_clr_cnt(clr), .SC_start_ok(okA),
    .SC_glitch(glA), .SC_busy(busyA),
    .SC_cfg_err(cfgA), .SC_glitch_cnt(cntA)
  );

  strt_validator #(
    .PRESCALE_W(6), .SAMPLES(5), .CNT_W(8)
  ) dutB (
    .CLK(CLK), .RST(RST), .SC_EN(enB),
    .SC_RX_IN(rx), .SC_Prescale(pre),
    .SC_clr_cnt(clr), .SC_start_ok(okB),
    .SC_glitch(glB), .SC_busy(busyB),
    .SC_cfg_err(cfgB), .SC_glitch_cnt(cntB)
  );

  always #5 CLK = ~CLK;

  bit   sel = 1'b0;
  logic curOk, curGl, curBusy, curCfg;
  assign curOk   = sel ? okB   : okA;
  assign curGl   = sel ? glB   : glA;
  assign curBusy = sel ? busyB : busyA;
  assign curCfg  = sel ? cfgB  : cfgA;

  int checks = 0;
  int errors = 0;
  int idx, npulse, fk, fa, lk, la, busyCnt, nGl;
  int expCnt = 0;

  typedef struct {
    bit          sel;
    int          p;
    logic [63:0] mask;
    int          n;
    int          fk;
    int          fa;
    int          lk;
    int          la;
    int          busy;
    int          gl;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clearMon();
    idx = 0; npulse = 0; fk = 0; fa = 0;
    lk = 0; la = 0; busyCnt = 0; nGl = 0;
  endtask

  task automatic step();
    int k;
    @(posedge CLK);
    #1;
    if (curOk || curGl) begin
      k = (curOk && curGl) ? 3 : (curOk ? 1 : 2);
      if (npulse == 0) begin
        fk = k;
        fa = idx;
      end
      lk = k;
      la = idx;
      npulse++;
      if (curGl) nGl++;
    end
    if (curBusy) busyCnt++;
    idx++;
  endtask

  task automatic setSel(input bit b);
    sel = b;
    enA = !b;
    enB = b;
  endtask

  task automatic idle(input int k);
    rx = 1'b1;
    repeat (k) step();
  endtask

  task automatic play(input logic [63:0] m, input int steps);
    clearMon();
    for (int i = 0; i < steps; i++) begin
      rx = (i < 64) ? ~m[i] : 1'b1;
      step();
    end
    rx = 1'b1;
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  initial begin
    logic [63:0] gm;
    int s;
    gm = 64'h3;

    setSel(1'b0);
    RST = 1'b1;
    pre = 6'd8;
    repeat (2) step();
    chk("rst_ok", okA, 0);
    chk("rst_glitch", glA, 0);
    chk("rst_busy", busyA, 0);
    chk("rst_cnt", cntA, 0);
    chk("rst_cfgA", cfgA, 0);
    chk("rst_cfgB", cfgB, 1);
    RST = 1'b0;
    idle(3);

    tv[0]  = '{1'b0,  8, 64'hFF,         1, 1,  7, 1,  7,  7, 0};
    tv[1]  = '{1'b0,  8, 64'h3,          1, 2,  5, 2,  5,  5, 1};
    tv[2]  = '{1'b1, 16, 64'hFD7F,       1, 1, 15, 1, 15, 15, 0};
    tv[3]  = '{1'b1, 16, 64'h281,        1, 2, 10, 2, 10, 10, 0};
    tv[4]  = '{1'b0,  8, 64'hFF_FFFF_FFFF, 1, 1, 7, 1,  7,  7, 0};
    tv[5]  = '{1'b0,  5, 64'hFF,         0, 0,  0, 0,  0,  0, 0};
    tv[6]  = '{1'b0,  8, 64'hEF,         1, 1,  7, 1,  7,  7, 0};
    tv[7]  = '{1'b0,  8, 64'h11,         1, 2,  5, 2,  5,  5, 1};
    tv[8]  = '{1'b0,  6, 64'h3F,         1, 1,  5, 1,  5,  5, 0};
    tv[9]  = '{1'b0,  9, 64'h1FF,        1, 1,  8, 1,  8,  8, 0};
    tv[10] = '{1'b0,  8, 64'h3FC3,       2, 2,  5, 1, 13, 12, 1};
    tv[11] = '{1'b1, 10, 64'h3FF,        1, 1,  9, 1,  9,  9, 0};

    for (int v = 0; v < 12; v++) begin
      pre = 6'(tv[v].p);
      setSel(tv[v].sel);
      idle(4);
      s = tv[v].sel ? 5 : 3;
      chk($sformatf("v%0d_cfg", v), curCfg,
          (tv[v].p < 2 * s) ? 1 : 0);
      play(tv[v].mask, 56);
      chk($sformatf("v%0d_npulse", v), npulse, tv[v].n);
      chk($sformatf("v%0d_firstKind", v), fk, tv[v].fk);
      chk($sformatf("v%0d_firstAt", v), fa, tv[v].fa);
      chk($sformatf("v%0d_lastKind", v), lk, tv[v].lk);
      chk($sformatf("v%0d_lastAt", v), la, tv[v].la);
      chk($sformatf("v%0d_busy", v), busyCnt, tv[v].busy);
      expCnt = sat3(expCnt + tv[v].gl);
      chk($sformatf("v%0d_cntA", v), cntA, expCnt);
    end

    // enable dropped at E+3
    setSel(1'b0);
    pre = 6'd8;
    idle(4);
    clearMon();
    rx = 1'b0;
    repeat (3) step();
    chk("abort_busy_before", busyA, 1);
    enA = 1'b0;
    step();
    chk("abort_busy_after", busyA, 0);
    repeat (4) step();
    rx = 1'b1;
    repeat (10) step();
    chk("abort_npulse", npulse, 0);
    enA = 1'b1;
    chk("abort_cnt_kept", cntA, expCnt);

    // reset at E+4 with line released
    idle(4);
    clearMon();
    rx = 1'b0;
    repeat (4) step();
    chk("rstmid_busy_before", busyA, 1);
    RST = 1'b1;
    rx = 1'b1;
    step();
    chk("rstmid_ok", okA, 0);
    chk("rstmid_glitch", glA, 0);
    chk("rstmid_busy", busyA, 0);
    chk("rstmid_cnt", cntA, 0);
    RST = 1'b0;
    repeat (12) step();
    chk("rstmid_npulse", npulse, 0);
    expCnt = 0;

    // prescale changed mid-frame, then too small
    idle(4);
    clearMon();
    rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) pre = 6'd4;
      step();
    end
    rx = 1'b1;
    repeat (10) step();
    chk("cfgchg_npulse", npulse, 1);
    chk("cfgchg_kind", fk, 1);
    chk("cfgchg_at", fa, 7);
    chk("cfgchg_cfgerr", cfgA, 1);
    play(64'hFF, 16);
    chk("cfgchg_ignored", npulse, 0);
    chk("cfgchg_ignored_busy", busyCnt, 0);
    pre = 6'd8;

    // saturation
    for (int k = 1; k <= 5; k++) begin
      idle(4);
      play(64'h3, 12);
      chk($sformatf("sat_g%0d", k), cntA, sat3(k));
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_cnt", cntA, 0);

    // clear coincident with a glitch
    idle(4);
    clearMon();
    for (int i = 0; i < 12; i++) begin
      rx  = ~gm[i];
      clr = (i == 5 || i == 6);
      step();
    end
    rx  = 1'b1;
    clr = 1'b0;
    chk("clrglitch_seen", nGl, 1);
    chk("clrglitch_cnt", cntA, 0);
    idle(4);
    play(64'h3, 12);
    chk("count_after_clr", cntA, 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
